// File: rtl/wash_cycle_controller.sv
// -----------------------------------------------------------------------------
// wash_cycle_controller
//
// Runs one laundry cycle through FILL -> WASH -> RINSE -> SPIN -> DRY -> DONE.
// The program select chooses the phases. A phase whose duration parameter is 0
// is skipped with no zero-length state. Each timed phase lasts DUR*TICK_DIV
// unfrozen clocks. A prescaler produces one tick every TICK_DIV clocks.
//
// Ports
//   clk, reset            clock, asynchronous active-high reset
//   power                 0 = freeze all state (abort still works)
//   start                 starts a cycle from IDLE or DONE and latches program_sel
//   abort                 synchronous return to IDLE, clears counters
//   pause                 1 = freeze prescaler, tick counter and state
//   ack                   leaves DONE for IDLE (start wins if both are high)
//   program_sel[1:0]      00 full, 01 quick, 10 no-dry, 11 dry-only
//   water_full            fill sensor
//   detergent_full        detergent sensor
//   *_ongoing             one registered flag per phase state
//   finished              registered, high while in DONE
//   state[2:0]            0 IDLE .. 6 DONE
//   remaining[CNT_W-1:0]  ticks left in the current timed phase, else 0
// -----------------------------------------------------------------------------
module wash_cycle_controller #(
   parameter int TICK_DIV = 20000000,
   parameter int CNT_W    = 8,
   parameter int WASH_T   = 12,
   parameter int RINSE_T  = 6,
   parameter int SPIN_T   = 8,
   parameter int DRY_T    = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             power,
   input  logic             start,
   input  logic             abort,
   input  logic             pause,
   input  logic             ack,
   input  logic [1:0]       program_sel,
   input  logic             water_full,
   input  logic             detergent_full,
   output logic             fill_ongoing,
   output logic             wash_ongoing,
   output logic             rinse_ongoing,
   output logic             spin_ongoing,
   output logic             dry_ongoing,
   output logic             finished,
   output logic [2:0]       state,
   output logic [CNT_W-1:0] remaining
);

   localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_FILL  = 3'd1;
   localparam logic [2:0] S_WASH  = 3'd2;
   localparam logic [2:0] S_RINSE = 3'd3;
   localparam logic [2:0] S_SPIN  = 3'd4;
   localparam logic [2:0] S_DRY   = 3'd5;
   localparam logic [2:0] S_DONE  = 3'd6;

   // Enabled phases for a program, bit order {dry, spin, rinse, wash}.
   function automatic logic [3:0] phase_en(input logic [1:0] p);
      logic [3:0] en;
      en[0] = (p != 2'b11) && (WASH_T != 0);
      en[1] = ((p == 2'b00) || (p == 2'b10)) && (RINSE_T != 0);
      en[2] = (p != 2'b11) && (SPIN_T != 0);
      en[3] = ((p == 2'b00) || (p == 2'b11)) && (DRY_T != 0);
      return en;
   endfunction

   function automatic logic [CNT_W-1:0] phase_dur(input logic [2:0] s);
      logic [CNT_W-1:0] d;
      d = '0;
      case (s)
         S_WASH:  d = CNT_W'(WASH_T);
         S_RINSE: d = CNT_W'(RINSE_T);
         S_SPIN:  d = CNT_W'(SPIN_T);
         S_DRY:   d = CNT_W'(DRY_T);
         default: d = '0;
      endcase
      return d;
   endfunction

   // First enabled phase strictly after 'from'. Phase state codes are 2..5.
   // The loop scans downward so that the lowest qualifying phase wins.
   function automatic logic [2:0] next_phase(input logic [2:0] from, input logic [3:0] en);
      logic [2:0] r;
      r = S_DONE;
      for (int i = 3; i >= 0; i--) begin
         if (en[i] && (3'(i + 2) > from)) r = 3'(i + 2);
      end
      return r;
   endfunction

   logic [2:0]       state_q, state_d;
   logic [PRE_W-1:0] pre_q, pre_d;
   logic [CNT_W-1:0] elapsed_q, elapsed_d;
   logic [1:0]       prog_q, prog_d;
   logic             fill_q, wash_q, rinse_q, spin_q, dry_q, finished_q;
   logic             fill_d, wash_d, rinse_d, spin_d, dry_d, finished_d;
   logic [CNT_W-1:0] remaining_q, remaining_d;

   logic [3:0]       en_start, en_run;
   logic [CNT_W-1:0] dur_m1;
   logic             tick;

   // A start uses the incoming program. A running cycle uses the latched program.
   assign en_start = phase_en(program_sel);
   assign en_run   = phase_en(prog_q);
   assign dur_m1   = phase_dur(state_q) - CNT_W'(1);
   assign tick     = (pre_q == PRE_MAX);

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         pre_q       <= '0;
         elapsed_q   <= '0;
         prog_q      <= 2'b00;
         fill_q      <= 1'b0;
         wash_q      <= 1'b0;
         rinse_q     <= 1'b0;
         spin_q      <= 1'b0;
         dry_q       <= 1'b0;
         finished_q  <= 1'b0;
         remaining_q <= '0;
      end else begin
         state_q     <= state_d;
         pre_q       <= pre_d;
         elapsed_q   <= elapsed_d;
         prog_q      <= prog_d;
         fill_q      <= fill_d;
         wash_q      <= wash_d;
         rinse_q     <= rinse_d;
         spin_q      <= spin_d;
         dry_q       <= dry_d;
         finished_q  <= finished_d;
         remaining_q <= remaining_d;
      end
   end

   // Next state
   always_comb begin
      state_d   = state_q;
      pre_d     = pre_q;
      elapsed_d = elapsed_q;
      prog_d    = prog_q;
      if (abort) begin
         state_d   = S_IDLE;
         pre_d     = '0;
         elapsed_d = '0;
      end else if (power && !pause) begin
         case (state_q)
            S_IDLE, S_DONE: begin
               pre_d     = '0;
               elapsed_d = '0;
               if (start) begin
                  prog_d = program_sel;
                  if (en_start[0] || en_start[1]) state_d = S_FILL;
                  else                            state_d = next_phase(S_FILL, en_start);
               end else if ((state_q == S_DONE) && ack) begin
                  state_d = S_IDLE;
               end
            end
            S_FILL: begin
               pre_d     = '0;
               elapsed_d = '0;
               if (water_full && detergent_full) state_d = next_phase(S_FILL, en_run);
            end
            S_WASH, S_RINSE, S_SPIN, S_DRY: begin
               if (tick) begin
                  pre_d = '0;
                  if (elapsed_q == dur_m1) begin
                     state_d   = next_phase(state_q, en_run);
                     elapsed_d = '0;
                  end else begin
                     elapsed_d = elapsed_q + CNT_W'(1);
                  end
               end else begin
                  pre_d = pre_q + PRE_W'(1);
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   // Outputs are registered from the next-state values, so they move with state.
   always_comb begin
      fill_d      = (state_d == S_FILL);
      wash_d      = (state_d == S_WASH);
      rinse_d     = (state_d == S_RINSE);
      spin_d      = (state_d == S_SPIN);
      dry_d       = (state_d == S_DRY);
      finished_d  = (state_d == S_DONE);
      remaining_d = '0;
      if ((state_d >= S_WASH) && (state_d <= S_DRY))
         remaining_d = phase_dur(state_d) - elapsed_d;
   end

   assign fill_ongoing  = fill_q;
   assign wash_ongoing  = wash_q;
   assign rinse_ongoing = rinse_q;
   assign spin_ongoing  = spin_q;
   assign dry_ongoing   = dry_q;
   assign finished      = finished_q;
   assign state         = state_q;
   assign remaining     = remaining_q;

endmodule

// File: tb/tb_wash_cycle_controller.sv
module tb_wash_cycle_controller;

   logic clk, reset, power, start, abort, pause, ack;
   logic [1:0] program_sel;
   logic water_full, detergent_full;

   logic fill1, wash1, rinse1, spin1, dry1, fin1;
   logic [2:0] state1;
   logic [7:0] rem1;
   logic fill2, wash2, rinse2, spin2, dry2, fin2;
   logic [2:0] state2;
   logic [7:0] rem2;

   wash_cycle_controller #(.TICK_DIV(4), .CNT_W(8), .WASH_T(3), .RINSE_T(2), .SPIN_T(2), .DRY_T(1)) dut (
      .clk(clk), .reset(reset), .power(power), .start(start), .abort(abort), .pause(pause),
      .ack(ack), .program_sel(program_sel), .water_full(water_full), .detergent_full(detergent_full),
      .fill_ongoing(fill1), .wash_ongoing(wash1), .rinse_ongoing(rinse1), .spin_ongoing(spin1),
      .dry_ongoing(dry1), .finished(fin1), .state(state1), .remaining(rem1));

   wash_cycle_controller #(.TICK_DIV(4), .CNT_W(8), .WASH_T(3), .RINSE_T(0), .SPIN_T(2), .DRY_T(1)) dut_norinse (
      .clk(clk), .reset(reset), .power(power), .start(start), .abort(abort), .pause(pause),
      .ack(ack), .program_sel(program_sel), .water_full(water_full), .detergent_full(detergent_full),
      .fill_ongoing(fill2), .wash_ongoing(wash2), .rinse_ongoing(rinse2), .spin_ongoing(spin2),
      .dry_ongoing(dry2), .finished(fin2), .state(state2), .remaining(rem2));

   typedef struct {
      int         cyc;
      bit         which;
      logic [2:0] st;
      logic [7:0] rem;
      string      tag;
   } sb_entry_t;

   sb_entry_t sb_q[$];
   int vec_cnt = 0;
   int err_cnt = 0;
   int cyc = 0;
   int b;
   logic fill_seen;

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vec_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [4:0] flags_for(input logic [2:0] st);
      logic [4:0] f;
      f = 5'b00000;
      case (st)
         3'd1: f = 5'b10000;
         3'd2: f = 5'b01000;
         3'd3: f = 5'b00100;
         3'd4: f = 5'b00010;
         3'd5: f = 5'b00001;
         default: f = 5'b00000;
      endcase
      return f;
   endfunction

   task automatic expect_at(input int c, input bit which, input logic [2:0] st,
                            input logic [7:0] rem, input string tag);
      sb_entry_t e;
      e.cyc = c; e.which = which; e.st = st; e.rem = rem; e.tag = tag;
      sb_q.push_back(e);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_to(input int t);
      while (cyc < t) step();
   endtask

   // Scoreboard: pops every expectation that falls due on this cycle.
   always @(negedge clk) begin : sb_monitor
      sb_entry_t e;
      logic [2:0] st_g;
      logic [7:0] rem_g;
      logic [4:0] fl_g;
      logic       fin_g;
      while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
         e = sb_q.pop_front();
         if (e.which == 1'b0) begin
            st_g = state1; rem_g = rem1; fl_g = {fill1, wash1, rinse1, spin1, dry1}; fin_g = fin1;
         end else begin
            st_g = state2; rem_g = rem2; fl_g = {fill2, wash2, rinse2, spin2, dry2}; fin_g = fin2;
         end
         $display("cycle %0d %s: state=%0d remaining=%0d flags=%05b finished=%0b",
                  cyc, e.tag, st_g, rem_g, fl_g, fin_g);
         if (e.cyc != cyc) begin
            check({e.tag, "_late"}, 32'(cyc), 32'(e.cyc));
         end else begin
            check({e.tag, "_state"}, 32'(st_g), 32'(e.st));
            check({e.tag, "_rem"}, 32'(rem_g), 32'(e.rem));
            check({e.tag, "_flags"}, 32'(fl_g), 32'(flags_for(e.st)));
            check({e.tag, "_fin"}, 32'(fin_g), 32'(e.st == 3'd6));
         end
      end
   end

   initial begin
      reset = 1'b1; power = 1'b1; start = 1'b0; abort = 1'b0; pause = 1'b0; ack = 1'b0;
      program_sel = 2'b00; water_full = 1'b1; detergent_full = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_state", 32'(state1), 32'd0);
      check("rst_flags", 32'({fill1, wash1, rinse1, spin1, dry1, fin1}), 32'd0);
      check("rst_rem", 32'(rem1), 32'd0);
      reset = 1'b0;
      step();

      // Full program, nominal timing, then ack
      b = cyc;
      start = 1'b1;
      expect_at(b+1,  0, 3'd1, 8'd0, "t1_fill");
      expect_at(b+2,  0, 3'd2, 8'd3, "t1_wash_in");
      expect_at(b+5,  0, 3'd2, 8'd3, "t1_wash_pre_tick");
      expect_at(b+6,  0, 3'd2, 8'd2, "t1_wash_tick1");
      expect_at(b+10, 0, 3'd2, 8'd1, "t1_wash_tick2");
      expect_at(b+13, 0, 3'd2, 8'd1, "t1_wash_last");
      expect_at(b+14, 0, 3'd3, 8'd2, "t1_rinse_in");
      expect_at(b+18, 0, 3'd3, 8'd1, "t1_rinse_tick");
      expect_at(b+22, 0, 3'd4, 8'd2, "t1_spin_in");
      expect_at(b+26, 0, 3'd4, 8'd1, "t1_spin_tick");
      expect_at(b+30, 0, 3'd5, 8'd1, "t1_dry_in");
      expect_at(b+33, 0, 3'd5, 8'd1, "t1_dry_last");
      expect_at(b+34, 0, 3'd6, 8'd0, "t1_done");
      expect_at(b+40, 0, 3'd6, 8'd0, "t1_done_held");
      expect_at(b+41, 0, 3'd0, 8'd0, "t1_ack_idle");
      step();
      start = 1'b0;
      wait_to(b+40);
      ack = 1'b1;
      step();
      ack = 1'b0;

      // Dry-only with sensors low; program change after start has no effect
      wait_to(b+42);
      b = cyc;
      program_sel = 2'b11; water_full = 1'b0; detergent_full = 1'b0; start = 1'b1;
      fill_seen = 1'b0;
      expect_at(b+1, 0, 3'd5, 8'd1, "t2_dry_in");
      expect_at(b+4, 0, 3'd5, 8'd1, "t2_dry_last");
      expect_at(b+5, 0, 3'd6, 8'd0, "t2_done");
      expect_at(b+7, 0, 3'd0, 8'd0, "t2_ack_idle");
      step();
      start = 1'b0; program_sel = 2'b00;
      while (cyc < b+6) begin
         if (fill1) fill_seen = 1'b1;
         step();
      end
      check("t2_no_fill", 32'(fill_seen), 32'd0);
      ack = 1'b1;
      step();
      ack = 1'b0;
      water_full = 1'b1; detergent_full = 1'b1;

      // Pause 5 cycles mid-WASH, then abort during SPIN
      wait_to(b+8);
      b = cyc;
      start = 1'b1;
      expect_at(b+1,  0, 3'd1, 8'd0, "t3_fill");
      expect_at(b+2,  0, 3'd2, 8'd3, "t3_wash_in");
      expect_at(b+7,  0, 3'd2, 8'd2, "t3_pause_start");
      expect_at(b+12, 0, 3'd2, 8'd2, "t3_pause_held");
      expect_at(b+18, 0, 3'd2, 8'd1, "t3_wash_last");
      expect_at(b+19, 0, 3'd3, 8'd2, "t3_rinse_late");
      expect_at(b+27, 0, 3'd4, 8'd2, "t4_spin_in");
      expect_at(b+29, 0, 3'd4, 8'd2, "t4_spin_mid");
      expect_at(b+30, 0, 3'd0, 8'd0, "t4_abort_idle");
      step();
      start = 1'b0;
      wait_to(b+7);
      pause = 1'b1;
      wait_to(b+12);
      pause = 1'b0;
      wait_to(b+29);
      abort = 1'b1;
      step();
      abort = 1'b0;
      b = cyc;
      start = 1'b1;
      expect_at(b+1, 0, 3'd1, 8'd0, "t4_restart_fill");
      expect_at(b+2, 0, 3'd2, 8'd3, "t4_restart_wash");
      step();
      start = 1'b0;
      wait_to(b+3);
      pause = 1'b1; abort = 1'b1;
      expect_at(b+4, 0, 3'd0, 8'd0, "t4_abort_over_pause");
      step();
      pause = 1'b0; abort = 1'b0;

      // Asynchronous reset mid-RINSE
      wait_to(b+6);
      b = cyc;
      start = 1'b1;
      expect_at(b+14, 0, 3'd3, 8'd2, "t5_rinse_in");
      expect_at(b+15, 0, 3'd3, 8'd2, "t5_rinse_mid");
      step();
      start = 1'b0;
      wait_to(b+16);
      #3;
      reset = 1'b1; start = 1'b1;
      #1;
      check("t5_async_state", 32'(state1), 32'd0);
      check("t5_async_flags", 32'({fill1, wash1, rinse1, spin1, dry1, fin1}), 32'd0);
      check("t5_async_rem", 32'(rem1), 32'd0);
      step();
      check("t5_start_ignored", 32'(state1), 32'd0);
      #2;
      reset = 1'b0; start = 1'b0;
      step();
      check("t5_idle_after", 32'(state1), 32'd0);

      // No-dry program with RINSE_T=0, then start+ack together in DONE
      b = cyc;
      program_sel = 2'b10; start = 1'b1;
      expect_at(b+1,  1, 3'd1, 8'd0, "t6_fill");
      expect_at(b+2,  1, 3'd2, 8'd3, "t6_wash_in");
      expect_at(b+14, 0, 3'd3, 8'd2, "t6_ref_rinse");
      expect_at(b+14, 1, 3'd4, 8'd2, "t6_spin_in");
      expect_at(b+22, 1, 3'd6, 8'd0, "t6_done");
      expect_at(b+24, 1, 3'd6, 8'd0, "t6_done_held");
      expect_at(b+25, 1, 3'd1, 8'd0, "t6_restart_fill");
      expect_at(b+26, 1, 3'd2, 8'd3, "t6_restart_wash");
      expect_at(b+30, 0, 3'd6, 8'd0, "t6_ref_done");
      step();
      start = 1'b0;
      wait_to(b+24);
      start = 1'b1; ack = 1'b1;
      step();
      start = 1'b0; ack = 1'b0;
      wait_to(b+31);
      abort = 1'b1;
      step();
      abort = 1'b0;

      for (int i = 0; i < 10 && sb_q.size() > 0; i++) step();
      check("sb_drain", 32'(sb_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
